simon_decrypt_pipe: RTL and testbench

//  Self-contained SIMON32/64 decryptor: accepts 64-bit key and 32-bit ciphertext via valid/ready,

---
 rtl/simon_decrypt_pipe.sv | 175 +++++++++++++++++
 tb/tb_simon_decrypt_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_decrypt_pipe.sv
// simon_decrypt_pipe
//   SIMON32/64 decryptor. The core takes a 64-bit key and a 32-bit ciphertext
//   through a valid/ready handshake and expands the key schedule into an
//   internal 32x16 key RAM. It then runs the 32 decrypt rounds,
//   ROUNDS_PER_CYCLE of them per clock. The plaintext is held on plain_out
//   until the consumer accepts it.
//
// Parameters
//   ROUNDS_PER_CYCLE : decrypt rounds chained per clock (1,2,4,8,16,32)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : key_in / cipher_in valid
//   in_ready   : core idle and able to accept a job
//   key_in     : {k3,k2,k1,k0}, k0 = key_in[15:0]
//   cipher_in  : ciphertext {x,y}, x = [31:16]
//   out_valid  : plain_out valid
//   out_ready  : consumer accepts plain_out
//   plain_out  : recovered plaintext {x,y}
//   busy       : key expansion or decryption in progress
//
// Optional build macro
//   KEY_CACHE_EN : remember the last fully expanded key. A job that uses the
//                  same key skips key expansion.

module simon_decrypt_pipe #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] key_in,
  input  logic [31:0] cipher_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] plain_out,
  output logic        busy
);

  localparam int unsigned R          = ROUNDS_PER_CYCLE;
  // With R = 32 the step truncates to 0; the single group is also the last one.
  localparam logic [4:0]  ROUND_STEP = 5'(R);
  localparam logic [4:0]  LAST_GROUP = 5'(32 - R);
  localparam logic [4:0]  LAST_EXP   = 5'd27;
  localparam logic [15:0] KS_CONST   = 16'hFFFC;
  // z0 sequence of SIMON32. Bit i (LSB first) is z0[i].
  localparam logic [61:0] Z0         = 62'h19C3522FB386A45F;

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

  state_t      state;
  logic [4:0]  ctr;
  logic [31:0] data;
  logic [15:0] key_ram [32];
  logic        cache_hit;

  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  // Next key word while expanding: k[ctr+4] built from k[ctr], k[ctr+1], k[ctr+3].
  logic [15:0] ks_t;
  logic [15:0] ks_k3;
  logic [15:0] k_new;

  always_comb begin
    ks_k3 = key_ram[ctr + 5'd3];
    ks_t  = {ks_k3[2:0], ks_k3[15:3]} ^ key_ram[ctr + 5'd1];
    k_new = KS_CONST ^ {15'd0, Z0[ctr]} ^ key_ram[ctr] ^ ks_t ^ {ks_t[0], ks_t[15:1]};
  end

  // R chained decrypt rounds. Round j = ctr + r uses k[31-j], which is ~j in 5 bits.
  logic [31:0] dec_next;
  logic [15:0] rx;
  logic [15:0] ry;
  logic [15:0] rtmp;
  logic [4:0]  kidx;

  always_comb begin
    rx   = data[31:16];
    ry   = data[15:0];
    rtmp = '0;
    kidx = '0;
    for (int unsigned r = 0; r < R; r++) begin
      kidx = ~(ctr + 5'(r));
      rtmp = rx ^ simon_f(ry) ^ key_ram[kidx];
      rx   = ry;
      ry   = rtmp;
    end
    dec_next = {rx, ry};
  end

`ifdef KEY_CACHE_EN
  logic [63:0] cached_key;
  logic        cache_ok;

  // k0..k3 still hold the job's key when its expansion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cached_key <= '0;
      cache_ok   <= 1'b0;
    end else if (state == EXPAND && ctr == LAST_EXP) begin
      cached_key <= {key_ram[3], key_ram[2], key_ram[1], key_ram[0]};
      cache_ok   <= 1'b1;
    end
  end

  assign cache_hit = cache_ok && (key_in == cached_key);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plain_out <= '0;
      data      <= '0;
      ctr       <= '0;
      for (int unsigned i = 0; i < 32; i++) key_ram[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data     <= cipher_in;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            ctr      <= '0;
            if (cache_hit) begin
              state <= DECRYPT;
            end else begin
              key_ram[0] <= key_in[15:0];
              key_ram[1] <= key_in[31:16];
              key_ram[2] <= key_in[47:32];
              key_ram[3] <= key_in[63:48];
              state      <= EXPAND;
            end
          end
        end
        EXPAND: begin
          key_ram[ctr + 5'd4] <= k_new;
          if (ctr == LAST_EXP) begin
            state <= DECRYPT;
            ctr   <= '0;
          end else begin
            ctr <= ctr + 5'd1;
          end
        end
        DECRYPT: begin
          data <= dec_next;
          ctr  <= ctr + ROUND_STEP;
          if (ctr == LAST_GROUP) begin
            state     <= DONE;
            plain_out <= dec_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_decrypt_pipe.sv
// tb_simon_decrypt_pipe
//   Directed bench for simon_decrypt_pipe. The main instance runs at one round
//   per clock. Five more instances cover ROUNDS_PER_CYCLE = 2..32. Expected
//   plaintexts come from the published test vector and from a SIMON32/64
//   encryption model. They go into a queue when a job is accepted and are
//   popped when out_valid rises.

module tb_simon_decrypt_pipe;

  localparam int unsigned N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] key_in;
  logic [31:0] cipher_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] plain_out;
  logic        busy;

  logic        sw_valid;
  logic        sw_ready;
  logic [63:0] sw_key;
  logic [31:0] sw_cipher;
  logic [4:0]  sw_ir;
  logic [4:0]  sw_ov;
  logic [4:0]  sw_busy;
  logic [31:0] sw_pt [5];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [63:0] tb_cache_key = '0;
  bit          tb_cache_ok  = 1'b0;

  always #5 clk = ~clk;

  simon_decrypt_pipe #(.ROUNDS_PER_CYCLE(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_in    (key_in),
    .cipher_in (cipher_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out),
    .busy      (busy)
  );

  for (genvar g = 0; g < 5; g++) begin : g_sweep
    simon_decrypt_pipe #(.ROUNDS_PER_CYCLE(2 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (sw_ir[g]),
      .key_in    (sw_key),
      .cipher_in (sw_cipher),
      .out_valid (sw_ov[g]),
      .out_ready (sw_ready),
      .plain_out (sw_pt[g]),
      .busy      (sw_busy[g])
    );
  end

  // Reference SIMON32/64 encryption, written from the published algorithm.
  function automatic logic [15:0] m_rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [31:0] simon_enc(input logic [63:0] key, input logic [31:0] pt);
    string       zs = "11111010001001010110000111001101111101000100101011000011100110";
    logic [15:0] k [32];
    logic [15:0] t, x, y, tmp;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t    = m_rol(k[i-1], 13) ^ k[i-3];
      t    = t ^ m_rol(t, 15);
      k[i] = 16'hFFFC ^ k[i-4] ^ t ^ ((zs[i-4] == "1") ? 16'd1 : 16'd0);
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x   = y ^ ((m_rol(x, 1) & m_rol(x, 8)) ^ m_rol(x, 2)) ^ k[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [63:0] key);
`ifdef KEY_CACHE_EN
    if (tb_cache_ok && key == tb_cache_key) return N;
`endif
    return 28 + N;
  endfunction

  // One job on the main instance. hold = cycles out_ready stays low in DONE.
  // disturb = drive in_valid with other data while the core is busy.
  task automatic run_job(input logic [63:0] key, input logic [31:0] ct, input logic [31:0] pt,
                         input int hold, input bit disturb);
    int          lat;
    int          want_lat;
    logic [31:0] want;
    want_lat = exp_latency(key);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    key_in    = key;
    cipher_in = ct;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    key_in    = ~key;
    cipher_in = ~ct;
    exp_q.push_back(pt);
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (disturb && lat == 5) begin
        in_valid  = 1'b1;
        key_in    = key ^ 64'h0123_4567_89AB_CDEF;
        cipher_in = ct ^ 32'hDEAD_BEEF;
      end
      if (disturb && lat == 9) in_valid = 1'b0;
      if (disturb && lat == 7) chk("in_ready_busy", 64'(in_ready), 64'd0);
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    chk("latency", 64'(lat), 64'(want_lat));
    want = exp_q.pop_front();
    chk("plain_out", 64'(plain_out), 64'(want));
    tb_cache_key = key;
    tb_cache_ok  = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_plain_out", 64'(plain_out), 64'(want));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    if (hold > 0) begin
      in_valid  = 1'b1;
      key_in    = 64'hFFFF_0000_FFFF_0000;
      cipher_in = 32'h1234_5678;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);
    in_valid = 1'b0;
    if (hold > 0) begin
      step();
      chk("bubble_no_accept", 64'(busy), 64'd0);
      chk("bubble_in_ready", 64'(in_ready), 64'd1);
    end
  endtask

  // Reset pulse after the 10th decrypt cycle of a job.
  task automatic reset_mid(input logic [63:0] key, input logic [31:0] ct);
    int pre;
    pre = exp_latency(key) - N;
    key_in    = key;
    cipher_in = ct;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    repeat (pre + 10) step();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_plain_out", 64'(plain_out), 64'd0);
    tb_cache_ok = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic sweep(input logic [63:0] key, input logic [31:0] ct, input logic [31:0] pt);
    int seen [5];
    for (int g = 0; g < 5; g++) seen[g] = 0;
    sw_key    = key;
    sw_cipher = ct;
    sw_valid  = 1'b1;
    step();
    sw_valid  = 1'b0;
    chk("sweep_busy", 64'(sw_busy), 64'h1F);
    chk("sweep_in_ready", 64'(sw_ir), 64'h0);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      step();
      for (int g = 0; g < 5; g++)
        if (sw_ov[g] === 1'b1 && seen[g] == 0) seen[g] = cyc;
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("sweep_latency_r%0d", 2 << g), 64'(seen[g]), 64'(28 + 32 / (2 << g)));
      chk($sformatf("sweep_plain_r%0d", 2 << g), 64'(sw_pt[g]), 64'(pt));
    end
    sw_ready = 1'b1;
    step();
    sw_ready = 1'b0;
    chk("sweep_out_valid_drop", 64'(sw_ov), 64'h0);
  endtask

  initial begin
    logic [63:0] rk;
    logic [31:0] rp;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key_in    = '0;
    cipher_in = '0;
    sw_valid  = 1'b0;
    sw_ready  = 1'b0;
    sw_key    = '0;
    sw_cipher = '0;
    repeat (3) step();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_plain_out", 64'(plain_out), 64'd0);
    rst_n = 1'b1;
    step();

    // Published vector, then the same job with a long out_ready stall.
    run_job(64'h1918_1110_0908_0100, 32'hC69B_E9BB, 32'h6565_6877, 0, 1'b0);
    run_job(64'h1918_1110_0908_0100, 32'hC69B_E9BB, 32'h6565_6877, 20, 1'b0);

    // Model-generated jobs. The first is disturbed by in_valid while busy. The
    // second reuses that key with new data.
    rk = {$urandom, $urandom};
    rp = $urandom;
    run_job(rk, simon_enc(rk, rp), rp, 0, 1'b1);
    rp = $urandom;
    run_job(rk, simon_enc(rk, rp), rp, 0, 1'b0);
    run_job(64'd0, simon_enc(64'd0, 32'd0), 32'd0, 0, 1'b0);
    run_job('1, simon_enc('1, '1), '1, 0, 1'b0);

    sweep(64'h1918_1110_0908_0100, 32'hC69B_E9BB, 32'h6565_6877);

    // Abort a job with reset, then run a fresh job with the same key.
    reset_mid(64'h1918_1110_0908_0100, 32'hC69B_E9BB);
    run_job(64'h1918_1110_0908_0100, 32'hC69B_E9BB, 32'h6565_6877, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
